pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_tick_gen.sv | 34 +++
 rtl/pwm_capture.sv | 181 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, limits, FSM state type and saturation helper for
// the pwm_capture block and its prescaler.
package pwm_pkg;

  localparam int unsigned PWM_VAL_W = 5;
  localparam int unsigned PWM_CNT_W = 6;

  localparam logic [PWM_CNT_W-1:0] PWM_SAT     = PWM_CNT_W'(31);
  localparam logic [PWM_CNT_W-1:0] PWM_TIMEOUT = PWM_CNT_W'(63);

  // Explicit encodings keep the legacy state numbering.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_t;

  // Clamp a tick count to the published output range.
  function automatic logic [PWM_VAL_W-1:0] pwm_sat(input logic [PWM_CNT_W-1:0] v);
    if (v > PWM_SAT) return PWM_SAT[PWM_VAL_W-1:0];
    return v[PWM_VAL_W-1:0];
  endfunction

  function automatic logic pwm_over(input logic [PWM_CNT_W-1:0] v);
    return (v > PWM_SAT);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: measurement-tick prescaler.
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   restart - force the count back to 0 (aligns ticks to a rising edge)
//   tick    - high for one cycle on the terminal count CLK_PER_TICK-1
module pwm_tick_gen #(
  parameter int unsigned CLK_PER_TICK = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_PER_TICK);
  localparam logic [CW-1:0] TERM = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Not gated by restart: a tick landing on the closing rising edge still
  // belongs to the measurement being closed.
  assign tick = (cnt == TERM);

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// in units of CLK_PER_TICK clock cycles.
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   pwm_in - asynchronous PWM waveform
//   en     - publish completed measurements when high; outputs hold when low
//   period - last measured rise-to-rise time in ticks (saturates at 31)
//   duty   - last measured high time in ticks (saturates at 31)
//   valid  - one-cycle pulse when period/duty are loaded
//   err    - sticky timeout/saturation flag, cleared by the next good publish
// Build option: define PWM_CAPTURE_GLITCH_FILTER_EN to reject pulses of
// 2 clk cycles or less (adds 2 cycles of latency).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  input  logic                 en,
  output logic [PWM_VAL_W-1:0] period,
  output logic [PWM_VAL_W-1:0] duty,
  output logic                 valid,
  output logic                 err
);

  logic sync1;
  logic sync2;
  logic s_pwm;
  logic s_prev;
  logic rise;
  logic fall;
  logic tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      s_prev <= s_pwm;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync2};
      filt <= s_pwm;
    end
  end

  // The filtered level follows sync2 only once three consecutive samples
  // (sync2 and its two predecessors) agree.
  always_comb begin
    s_pwm = filt;
    if ((sync2 == hist[0]) && (sync2 == hist[1])) s_pwm = sync2;
  end
`else
  always_comb begin
    s_pwm = sync2;
  end
`endif

  assign rise = s_pwm & ~s_prev;
  assign fall = ~s_pwm & s_prev;

  // After reset the synchronizer starts at 0, so a pwm_in that is already
  // high would look like a rising edge. Starting a measurement is therefore
  // only allowed once the pipeline has settled and a low level was seen.
  logic [2:0] settle;
  logic       armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else if (settle != 3'd4) begin
      settle <= settle + 3'd1;
    end else if (!s_pwm) begin
      armed <= 1'b1;
    end
  end

  pwm_tick_gen #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(rise),
    .tick   (tick)
  );

  pwm_state_t           state;
  logic [PWM_CNT_W-1:0] tot_cnt;
  logic [PWM_CNT_W-1:0] hi_cnt;
  logic [PWM_CNT_W-1:0] tot_nxt;
  logic [PWM_CNT_W-1:0] hi_nxt;
  logic                 timeout;
  logic                 pend;
  logic [PWM_CNT_W-1:0] pend_tot;
  logic [PWM_CNT_W-1:0] pend_hi;

  assign tot_nxt = tot_cnt + PWM_CNT_W'(tick);
  assign hi_nxt  = hi_cnt + PWM_CNT_W'(tick);
  assign timeout = ((state == ST_HIGH) || (state == ST_LOW)) && (tot_nxt == PWM_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tot_cnt  <= '0;
      hi_cnt   <= '0;
      pend     <= 1'b0;
      pend_tot <= '0;
      pend_hi  <= '0;
    end else begin
      pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise && armed) begin
            state   <= ST_HIGH;
            tot_cnt <= '0;
            hi_cnt  <= '0;
          end
        end
        ST_HIGH: begin
          if (timeout) begin
            state <= ST_IDLE;
          end else begin
            tot_cnt <= tot_nxt;
            hi_cnt  <= hi_nxt;
            if (fall) state <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (timeout) begin
            state <= ST_IDLE;
          end else if (rise) begin
            // Snapshot includes this cycle's tick; publish happens next cycle.
            pend     <= 1'b1;
            pend_tot <= tot_nxt;
            pend_hi  <= hi_cnt;
            state    <= ST_HIGH;
            tot_cnt  <= '0;
            hi_cnt   <= '0;
          end else begin
            tot_cnt <= tot_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period <= '0;
      duty   <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= pend && en;
      if (pend && en) begin
        period <= pwm_sat(pend_tot);
        duty   <= pwm_sat(pend_hi);
        err    <= pwm_over(pend_tot) || pwm_over(pend_hi);
      end
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int N = 50;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic       en = 1'b1;
  logic [4:0] period;
  logic [4:0] duty;
  logic       valid;
  logic       err;

  pwm_capture #(.CLK_PER_TICK(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .en    (en),
    .period(period),
    .duty  (duty),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;

  typedef struct {
    int cyc;
    int p;
    int d;
    int e;
  } pub_t;
  pub_t exp_q[$];
  pub_t mon_x;
  int hold_p = 0;
  int hold_d = 0;

  bit have_rise = 0;
  bit fall_seen = 0;
  int last_rise = 0;
  int first_fall = 0;

  typedef struct {
    int h;
    int l;
    bit en;
    int ev;
    int ep;
    int ed;
    int ee;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a measurement runs from one rising edge of pwm_in to
  // the next; it is published LAT cycles after the closing edge unless the
  // period reached 63 ticks (timeout) or en is low.
  task automatic model_edge(input logic lvl);
    int p;
    int d;
    pub_t x;
    if (lvl) begin
      if (have_rise) begin
        p = (cyc - last_rise) / N;
        d = (first_fall - last_rise) / N;
        if (p < 63 && en) begin
          x.cyc = cyc + LAT;
          x.p = (p > 31) ? 31 : p;
          x.d = (d > 31) ? 31 : d;
          x.e = (p > 31 || d > 31) ? 1 : 0;
          exp_q.push_back(x);
        end
      end
      have_rise = 1;
      last_rise = cyc;
      fall_seen = 0;
    end else if (!fall_seen) begin
      fall_seen = 1;
      first_fall = cyc;
    end
  endtask

  task automatic seg(input logic lvl, input int len);
    if (lvl != pwm_in) model_edge(lvl);
    pwm_in = lvl;
    repeat (len) @(negedge clk);
  endtask

  task automatic glitch2();
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    model_edge(1'b0);
`endif
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    model_edge(1'b1);
`endif
    pwm_in = 1'b1;
  endtask

  task automatic check_vec(input int idx, input int dv);
    chk($sformatf("vec%0d_valid", idx), dv, tv[idx].ev);
    chk($sformatf("vec%0d_period", idx), period, tv[idx].ep);
    chk($sformatf("vec%0d_duty", idx), duty, tv[idx].ed);
    chk($sformatf("vec%0d_err", idx), err, tv[idx].ee);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst) begin
      if (valid) valid_cnt++;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        mon_x = exp_q.pop_front();
        chk("publish_valid", valid, 1);
        chk("publish_period", period, mon_x.p);
        chk("publish_duty", duty, mon_x.d);
        chk("publish_err", err, mon_x.e);
        hold_p = mon_x.p;
        hold_d = mon_x.d;
      end else begin
        chk("valid_quiet", valid, 0);
        chk("period_hold", period, hold_p);
        chk("duty_hold", duty, hold_d);
      end
    end
  end

  initial begin
    int v0;
    int gp;
    int gd;

    tv[0]  = '{150, 350, 1'b1, 1, 10, 3, 0};
    tv[1]  = '{150, 350, 1'b1, 1, 10, 3, 0};
    tv[2]  = '{1600, 400, 1'b1, 1, 31, 31, 1};
    tv[3]  = '{150, 350, 1'b1, 1, 10, 3, 0};
    tv[4]  = '{500, 500, 1'b1, 1, 20, 10, 0};
    tv[5]  = '{47, 3, 1'b1, 1, 1, 0, 0};
    tv[6]  = '{1547, 3, 1'b1, 1, 31, 30, 0};
    tv[7]  = '{1600, 50, 1'b1, 1, 31, 31, 1};
    tv[8]  = '{97, 3, 1'b1, 1, 2, 1, 0};
    tv[9]  = '{150, 350, 1'b0, 0, 2, 1, 0};
    tv[10] = '{150, 350, 1'b0, 0, 2, 1, 0};
    tv[11] = '{150, 350, 1'b1, 1, 10, 3, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_period", period, 0);
    chk("reset_duty", duty, 0);
    chk("reset_valid", valid, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;
    seg(1'b0, 20);

    // Table-driven frames: entry i is checked just after the rising edge
    // that closes it (start of entry i+1).
    for (int i = 0; i < 12; i++) begin
      v0 = valid_cnt;
      seg(1'b1, 8);
      if (i > 0) check_vec(i - 1, valid_cnt - v0);
      seg(1'b1, tv[i].h - 8);
      en = tv[i].en;
      seg(1'b0, tv[i].l);
    end
    v0 = valid_cnt;
    seg(1'b1, 8);
    check_vec(11, valid_cnt - v0);
    seg(1'b1, 142);
    seg(1'b0, 350);

    // Random frames against the reference model
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      seg(1'b1, $urandom_range(1700, 3));
      seg(1'b0, $urandom_range(900, 3));
    end
    seg(1'b1, 150);
    seg(1'b0, 350);

    // Timeout: one rising edge, then low for 4000 cycles
    seg(1'b1, 150);
    v0 = valid_cnt;
    seg(1'b0, 4000);
    chk("timeout_no_valid", valid_cnt - v0, 0);
    chk("timeout_err", err, 1);
    seg(1'b1, 150);
    seg(1'b0, 350);
    seg(1'b1, 10);
    chk("after_timeout_period", period, 10);
    chk("after_timeout_duty", duty, 3);
    chk("after_timeout_err", err, 0);
    seg(1'b1, 140);
    seg(1'b0, 350);

    // Reset in the middle of the high phase
    seg(1'b1, 60);
    #2 rst = 1'b1;
    #1;
    chk("midrst_period", period, 0);
    chk("midrst_duty", duty, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_err", err, 0);
    exp_q.delete();
    have_rise = 0;
    hold_p = 0;
    hold_d = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt;
    seg(1'b1, 90);
    seg(1'b0, 350);
    seg(1'b1, 150);
    seg(1'b0, 350);
    chk("midrst_no_valid_one_edge", valid_cnt - v0, 0);
    seg(1'b1, 10);
    chk("midrst_second_edge_valid", valid_cnt - v0, 1);
    chk("midrst_period_after", period, 10);
    chk("midrst_duty_after", duty, 3);
    seg(1'b1, 140);
    seg(1'b0, 350);

    // 2-cycle low glitch inside a 150-cycle high phase
    seg(1'b1, 150);
    seg(1'b0, 350);
    seg(1'b1, 100);
    glitch2();
    seg(1'b1, 10);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    gp = 10;
    gd = 3;
`else
    gp = 2;
    gd = 2;
`endif
    chk("glitch_period", period, gp);
    chk("glitch_duty", duty, gd);
    seg(1'b1, 38);
    seg(1'b0, 350);
    seg(1'b1, 150);
    seg(1'b0, 350);
    seg(1'b1, 10);
    seg(1'b0, 20);

    chk("pending_publishes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
